// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing for the FIFO stream adapters (read side now, write side later).
package fifo_stream_pkg;

    localparam int OCC_W     = 2;
    localparam int BUF_DEPTH = 2;

    typedef logic [OCC_W-1:0] occ_t;

    // True when one more pop can be issued without the output buffer overflowing.
    // Beats already committed = buffered + in flight; a fire this cycle frees one slot.
    function automatic logic credit_ok(input occ_t count, input logic inflight, input logic fire);
        logic [OCC_W:0] committed;
        logic [OCC_W:0] limit;
        committed = {1'b0, count} + {{OCC_W{1'b0}}, inflight};
        limit     = {1'b0, occ_t'(BUF_DEPTH)} + {{OCC_W{1'b0}}, fire};
        return committed < limit;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer with write/read strobes, 1-bit head/tail pointers and an
// occupancy count. The head entry is presented combinationally on rd_data.
module skid_buf2
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output occ_t                  count,
    output logic                  not_empty
);

    logic [DATA_WIDTH-1:0] entry_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] entry_d [BUF_DEPTH];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    occ_t                  count_q, count_d;

    // Next-state: clear wins; otherwise write at tail, pop at head, adjust count.
    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = '0;
        end else begin
            if (wr_en) begin
                entry_d[tail_q] = wr_data;
                tail_d          = ~tail_q;
            end
            if (rd_en) begin
                head_d = ~head_q;
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + occ_t'(1);
                2'b01:   count_d = count_q - occ_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset clears pointers, count and both entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '{default: '0};
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rd_data   = entry_q[head_q];
    assign count     = count_q;
    assign not_empty = (count_q != '0);

    // A write into a full buffer would land on the entry currently being presented.
    assert property (@(posedge clk) disable iff (rst) !(wr_en && !clr && count_q == occ_t'(BUF_DEPTH)));
    assert property (@(posedge clk) disable iff (rst) count_q <= occ_t'(BUF_DEPTH));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of async_fifo: converts the pop interface (empty / rd_en /
// registered read data) into a valid/ready stream through a 2-entry prefetch buffer.
// Pops are credit-limited so backpressure never drops a beat; flush discards
// buffered and in-flight beats.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output occ_t                  o_count
);

    logic                  inflight_q, inflight_d;
    logic                  fire;
    logic                  pop;
    logic                  capture;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    occ_t                  buf_count;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (i_flush),
        .wr_en     (capture),
        .wr_data   (i_fifo_rd_data),
        .rd_en     (fire),
        .rd_data   (buf_data),
        .count     (buf_count),
        .not_empty (buf_valid)
    );

    // Pop/capture control: pop only with credit, never while empty, flushing or in reset.
    always_comb begin
        fire       = buf_valid & i_ready;
        capture    = inflight_q & ~i_flush;
        pop        = ~i_rst & ~i_fifo_empty & ~i_flush & credit_ok(buf_count, inflight_q, fire);
        inflight_d = pop;
    end

    // Inflight marks that i_fifo_rd_data carries a popped beat this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign o_fifo_rd_en = pop;
    assign o_valid      = buf_valid;
    assign o_data       = buf_data;
    assign o_count      = buf_count;

endmodule
